// File: rtl/rv_mdu_ctrl.sv
// rv_mdu_ctrl: pipeline-side initiator for the multiply/divide unit.
// Accepts one M-extension op over a valid/ready handshake, drives the MDU
// request/kill/keep signals, waits out the MDU stall, captures the result
// and presents it to writeback over a second valid/ready handshake.
// Optional watchdog: define RV_MDU_CTRL_WDT_EN to abort EXEC after WDT_LIMIT
// stalled cycles (result 0, err_o set). Without it EXEC waits indefinitely.
module rv_mdu_ctrl #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned MDU_OP_W  = 3,
  parameter int unsigned WDT_LIMIT = 40
) (
  input  logic                clk_i,
  input  logic                arstn_i,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  logic [MDU_OP_W-1:0] issue_op_i,
  input  logic [XLEN-1:0]     issue_a_i,
  input  logic [XLEN-1:0]     issue_b_i,
  input  logic [4:0]          issue_rd_i,
  input  logic                flush_i,
  output logic                wb_valid_o,
  input  logic                wb_ready_i,
  output logic [XLEN-1:0]     wb_data_o,
  output logic [4:0]          wb_rd_o,
  output logic                err_o,
  output logic                mdu_req_o,
  output logic [MDU_OP_W-1:0] mdu_op_o,
  output logic [XLEN-1:0]     mdu_port_a_o,
  output logic [XLEN-1:0]     mdu_port_b_o,
  output logic                mdu_kill_o,
  output logic                mdu_keep_o,
  input  logic [XLEN-1:0]     mdu_result_i,
  input  logic                mdu_stall_req_i,
  output logic                busy_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [MDU_OP_W-1:0] op_q, op_d;
  logic [XLEN-1:0]     a_q, a_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [4:0]          rd_q, rd_d;
  logic [XLEN-1:0]     res_q, res_d;
  logic                accept;
  logic                wdt_fire;

`ifdef RV_MDU_CTRL_WDT_EN
  logic [5:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`endif

  // Issue handshake: flush blocks any accept; DONE can accept only when its
  // own result is leaving in the same cycle.
  always_comb begin
    issue_ready_o = !flush_i && ((state_q == S_IDLE) ||
                                 ((state_q == S_DONE) && wb_ready_i));
    accept        = issue_valid_i && issue_ready_o;
  end

  // Watchdog trip: still stalled in the WDT_LIMIT-th EXEC cycle.
  always_comb begin
`ifdef RV_MDU_CTRL_WDT_EN
    wdt_fire = (state_q == S_EXEC) && !flush_i && mdu_stall_req_i &&
               (cnt_q == 6'(WDT_LIMIT - 1));
`else
    wdt_fire = 1'b0;
`endif
  end

  // Next-state and register-capture logic.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rd_d    = rd_q;
    res_d   = res_q;
`ifdef RV_MDU_CTRL_WDT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: ;
      S_EXEC: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (!mdu_stall_req_i) begin
          res_d   = mdu_result_i;
          state_d = S_DONE;
        end else if (wdt_fire) begin
          res_d   = '0;
          state_d = S_DONE;
`ifdef RV_MDU_CTRL_WDT_EN
          err_d   = 1'b1;
`endif
        end else begin
`ifdef RV_MDU_CTRL_WDT_EN
          cnt_d   = cnt_q + 6'd1;
`endif
        end
      end
      S_DONE: begin
        if (flush_i || wb_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Accept overrides the IDLE fallback above, giving DONE->EXEC chaining.
    if (accept) begin
      state_d = S_EXEC;
      op_d    = issue_op_i;
      a_d     = issue_a_i;
      b_d     = issue_b_i;
      rd_d    = issue_rd_i;
`ifdef RV_MDU_CTRL_WDT_EN
      cnt_d   = '0;
      err_d   = 1'b0;
`endif
    end
  end

  // Output decode from state and registers.
  always_comb begin
    mdu_req_o    = (state_q == S_EXEC);
    mdu_keep_o   = (state_q == S_DONE);
    mdu_kill_o   = ((state_q == S_EXEC) && flush_i) || wdt_fire;
    wb_valid_o   = (state_q == S_DONE) && !flush_i;
    busy_o       = (state_q != S_IDLE);
    mdu_op_o     = op_q;
    mdu_port_a_o = a_q;
    mdu_port_b_o = b_q;
    wb_data_o    = res_q;
    wb_rd_o      = rd_q;
`ifdef RV_MDU_CTRL_WDT_EN
    err_o        = err_q;
`else
    err_o        = 1'b0;
`endif
  end

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      res_q   <= '0;
`ifdef RV_MDU_CTRL_WDT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
`ifdef RV_MDU_CTRL_WDT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_rv_mdu_ctrl.sv
// Testbench for rv_mdu_ctrl with a stub MDU whose stall length is chosen
// per operation. Expected results come from an M-extension arithmetic model.
module tb_rv_mdu_ctrl;

  localparam int XLEN = 32;
  localparam int OPW  = 3;
  localparam int WDT  = 40;

  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2,
                         OP_MULHU = 3'd3, OP_DIV = 3'd4, OP_DIVU = 3'd5,
                         OP_REM = 3'd6, OP_REMU = 3'd7;

  logic            clk = 1'b0;
  logic            arstn_i;
  logic            issue_valid_i;
  logic            issue_ready_o;
  logic [OPW-1:0]  issue_op_i;
  logic [XLEN-1:0] issue_a_i, issue_b_i;
  logic [4:0]      issue_rd_i;
  logic            flush_i;
  logic            wb_valid_o;
  logic            wb_ready_i;
  logic [XLEN-1:0] wb_data_o;
  logic [4:0]      wb_rd_o;
  logic            err_o;
  logic            mdu_req_o;
  logic [OPW-1:0]  mdu_op_o;
  logic [XLEN-1:0] mdu_port_a_o, mdu_port_b_o;
  logic            mdu_kill_o;
  logic            mdu_keep_o;
  logic [XLEN-1:0] mdu_result_i;
  logic            mdu_stall_req_i;
  logic            busy_o;

  int n_cmp = 0;
  int n_bad = 0;
  int stall_left;
  int next_stall = 0;

  always #5 clk = ~clk;

  rv_mdu_ctrl #(.XLEN(XLEN), .MDU_OP_W(OPW), .WDT_LIMIT(WDT)) dut (
    .clk_i(clk), .arstn_i(arstn_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_op_i(issue_op_i), .issue_a_i(issue_a_i), .issue_b_i(issue_b_i),
    .issue_rd_i(issue_rd_i), .flush_i(flush_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_data_o(wb_data_o),
    .wb_rd_o(wb_rd_o), .err_o(err_o),
    .mdu_req_o(mdu_req_o), .mdu_op_o(mdu_op_o),
    .mdu_port_a_o(mdu_port_a_o), .mdu_port_b_o(mdu_port_b_o),
    .mdu_kill_o(mdu_kill_o), .mdu_keep_o(mdu_keep_o),
    .mdu_result_i(mdu_result_i), .mdu_stall_req_i(mdu_stall_req_i),
    .busy_o(busy_o)
  );

  // RISC-V M-extension semantics, including div-by-zero and overflow cases.
  function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    int              sa, sb;
    sa = a;
    sb = b;
    case (op)
      OP_MUL:    ref_mdu = a * b;
      OP_MULH:   begin sp = longint'(sa) * longint'(sb); ref_mdu = sp[63:32]; end
      OP_MULHSU: begin sp = longint'(sa) * longint'({32'd0, b}); ref_mdu = sp[63:32]; end
      OP_MULHU:  begin up = {32'd0, a} * {32'd0, b}; ref_mdu = up[63:32]; end
      OP_DIV:    ref_mdu = (b == 0) ? 32'hFFFF_FFFF :
                           (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(sa / sb);
      OP_DIVU:   ref_mdu = (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:    ref_mdu = (b == 0) ? a :
                           (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
      default:   ref_mdu = (b == 0) ? a : a % b;
    endcase
  endfunction

  // Stub MDU: stalls for next_stall cycles from the first request cycle.
  always @(posedge clk) begin
    if (!arstn_i || mdu_kill_o)                stall_left <= 0;
    else if (issue_valid_i && issue_ready_o)   stall_left <= next_stall;
    else if (mdu_req_o && stall_left > 0)      stall_left <= stall_left - 1;
  end
  assign mdu_stall_req_i = mdu_req_o && (stall_left != 0);
  assign mdu_result_i    = ref_mdu(mdu_op_o, mdu_port_a_o, mdu_port_b_o);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    arstn_i = 1'b0; issue_valid_i = 1'b0; issue_op_i = '0; issue_a_i = '0;
    issue_b_i = '0; issue_rd_i = '0; flush_i = 1'b0; wb_ready_i = 1'b0;
    repeat (3) step();
    #1;
    n_cmp++; if (issue_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", issue_ready_o); end
    n_cmp++; if ({wb_valid_o, mdu_req_o, mdu_kill_o, mdu_keep_o, err_o, busy_o} !== 6'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 000000", {wb_valid_o, mdu_req_o, mdu_kill_o, mdu_keep_o, err_o, busy_o}); end
    n_cmp++; if ({wb_data_o, wb_rd_o, mdu_op_o, mdu_port_a_o, mdu_port_b_o} !== '0) begin
      n_bad++; $display("FAIL reset_regs: got data=%h rd=%0d op=%0d a=%h b=%h want all 0", wb_data_o, wb_rd_o, mdu_op_o, mdu_port_a_o, mdu_port_b_o); end
    arstn_i = 1'b1;
    step();
  endtask

  // One full transaction from IDLE: k stall cycles, then hold wb_ready low for hold cycles.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int k, input int hold);
    logic [31:0] exp;
    int lat;
    exp = ref_mdu(op, a, b);
    next_stall = k;
    issue_valid_i = 1'b1; issue_op_i = op; issue_a_i = a; issue_b_i = b; issue_rd_i = rd;
    wb_ready_i = 1'b0;
    #1;
    n_cmp++; if (issue_ready_o !== 1'b1) begin n_bad++; $display("FAIL op_idle_ready: got %b want 1", issue_ready_o); end
    step();
    issue_valid_i = 1'b0; issue_op_i = OPW'($urandom); issue_a_i = $urandom; issue_b_i = $urandom;
    issue_rd_i = 5'($urandom);
    #1;
    n_cmp++; if (mdu_req_o !== 1'b1) begin n_bad++; $display("FAIL op_req: got %b want 1", mdu_req_o); end
    n_cmp++; if (mdu_op_o !== op) begin n_bad++; $display("FAIL op_mdu_op: got %0d want %0d", mdu_op_o, op); end
    lat = 1;
    while (wb_valid_o !== 1'b1 && lat < 200) begin
      n_cmp++; if (issue_ready_o !== 1'b0) begin n_bad++; $display("FAIL op_exec_ready: got %b want 0 (cycle %0d)", issue_ready_o, lat); end
      step(); #1;
      lat++;
    end
    n_cmp++; if (lat != 2 + k) begin n_bad++; $display("FAIL op_latency: got %0d want %0d (op %0d)", lat, 2 + k, op); end
    n_cmp++; if (wb_data_o !== exp) begin n_bad++; $display("FAIL op_data: got %h want %h (op %0d a=%h b=%h)", wb_data_o, exp, op, a, b); end
    n_cmp++; if (wb_rd_o !== rd) begin n_bad++; $display("FAIL op_rd: got %0d want %0d", wb_rd_o, rd); end
    n_cmp++; if ({err_o, mdu_keep_o, mdu_req_o} !== 3'b010) begin
      n_bad++; $display("FAIL op_done_ctrl: got err/keep/req=%b want 010", {err_o, mdu_keep_o, mdu_req_o}); end
    repeat (hold) begin
      step(); #1;
      n_cmp++; if ({wb_valid_o, mdu_keep_o, mdu_req_o, wb_data_o, wb_rd_o} !== {3'b110, exp, rd}) begin
        n_bad++; $display("FAIL op_hold: got v/k/r=%b data=%h rd=%0d want 110 %h %0d",
                          {wb_valid_o, mdu_keep_o, mdu_req_o}, wb_data_o, wb_rd_o, exp, rd); end
    end
    wb_ready_i = 1'b1;
    #1;
    n_cmp++; if (issue_ready_o !== 1'b1) begin n_bad++; $display("FAIL op_done_ready: got %b want 1", issue_ready_o); end
    step();
    wb_ready_i = 1'b0;
    #1;
    n_cmp++; if ({busy_o, wb_valid_o} !== 2'b00) begin n_bad++; $display("FAIL op_back_idle: got busy/valid=%b want 00", {busy_o, wb_valid_o}); end
  endtask

  task automatic test_directed();
    run_op(OP_MUL,  32'd7, 32'd6, 5'd5, 0, 0);
    run_op(OP_DIV,  -32'sd20, 32'd3, 5'd1, 6, 0);
    run_op(OP_REM,  -32'sd20, 32'd3, 5'd2, 6, 0);
    run_op(OP_DIVU, 32'd5, 32'd0, 5'd3, 4, 5);
    run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 3, 1);
    run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd31, 3, 0);
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom);
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      run_op(op, a, b, 5'($urandom), op[2] ? int'($urandom_range(1, 9)) : 0, int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_flush_exec();
    next_stall = 6;
    issue_valid_i = 1'b1; issue_op_i = OP_DIV; issue_a_i = 32'd100; issue_b_i = 32'd7; issue_rd_i = 5'd9;
    step();
    issue_valid_i = 1'b0;
    step();
    step();
    flush_i = 1'b1;
    #1;
    n_cmp++; if ({mdu_kill_o, mdu_req_o, wb_valid_o, issue_ready_o} !== 4'b1100) begin
      n_bad++; $display("FAIL flush_exec_kill: got kill/req/valid/ready=%b want 1100", {mdu_kill_o, mdu_req_o, wb_valid_o, issue_ready_o}); end
    step();
    flush_i = 1'b0;
    #1;
    n_cmp++; if ({mdu_kill_o, busy_o, mdu_req_o, issue_ready_o} !== 4'b0001) begin
      n_bad++; $display("FAIL flush_exec_idle: got kill/busy/req/ready=%b want 0001", {mdu_kill_o, busy_o, mdu_req_o, issue_ready_o}); end
    repeat (4) begin
      step();
      n_cmp++; if (wb_valid_o !== 1'b0) begin n_bad++; $display("FAIL flush_exec_nowb: got %b want 0", wb_valid_o); end
    end
    run_op(OP_MUL, 32'd3, 32'd3, 5'd6, 0, 0);
  endtask

  task automatic test_flush_done_idle();
    next_stall = 0;
    issue_valid_i = 1'b1; issue_op_i = OP_MUL; issue_a_i = 32'd11; issue_b_i = 32'd13; issue_rd_i = 5'd8;
    step();
    issue_valid_i = 1'b0;
    step();
    n_cmp++; if (wb_valid_o !== 1'b1) begin n_bad++; $display("FAIL flush_done_pre: got %b want 1", wb_valid_o); end
    flush_i = 1'b1; wb_ready_i = 1'b1; issue_valid_i = 1'b1;
    #1;
    n_cmp++; if ({wb_valid_o, issue_ready_o, mdu_keep_o} !== 3'b001) begin
      n_bad++; $display("FAIL flush_done_mask: got valid/ready/keep=%b want 001", {wb_valid_o, issue_ready_o, mdu_keep_o}); end
    step();
    #1;
    n_cmp++; if ({busy_o, issue_ready_o} !== 2'b00) begin n_bad++; $display("FAIL flush_idle_noaccept: got busy/ready=%b want 00", {busy_o, issue_ready_o}); end
    step();
    flush_i = 1'b0; issue_valid_i = 1'b0; wb_ready_i = 1'b0;
    #1;
    n_cmp++; if ({busy_o, mdu_req_o, wb_valid_o} !== 3'b000) begin
      n_bad++; $display("FAIL flush_idle_state: got busy/req/valid=%b want 000", {busy_o, mdu_req_o, wb_valid_o}); end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ops [8];
    logic [31:0] as [8];
    logic [31:0] bs [8];
    ops[0] = OP_MUL; as[0] = 32'd2; bs[0] = 32'd2;
    for (int i = 1; i < 8; i++) begin
      ops[i] = {1'b0, 2'($urandom)}; as[i] = $urandom; bs[i] = $urandom;
    end
    next_stall = 0; wb_ready_i = 1'b1;
    issue_valid_i = 1'b1; issue_op_i = ops[0]; issue_a_i = as[0]; issue_b_i = bs[0]; issue_rd_i = 5'd0;
    step();
    for (int i = 0; i < 8; i++) begin
      if (i < 7) begin
        issue_op_i = ops[i+1]; issue_a_i = as[i+1]; issue_b_i = bs[i+1]; issue_rd_i = 5'(i + 1);
      end else begin
        issue_valid_i = 1'b0;
      end
      #1;
      n_cmp++; if ({busy_o, mdu_req_o, wb_valid_o, issue_ready_o} !== 4'b1100) begin
        n_bad++; $display("FAIL b2b_exec: got busy/req/valid/ready=%b want 1100 (op %0d)", {busy_o, mdu_req_o, wb_valid_o, issue_ready_o}, i); end
      step();
      n_cmp++; if ({wb_valid_o, issue_ready_o, busy_o, wb_data_o, wb_rd_o} !== {3'b111, ref_mdu(ops[i], as[i], bs[i]), 5'(i)}) begin
        n_bad++; $display("FAIL b2b_done: got v/r/b=%b data=%h rd=%0d want 111 %h %0d",
                          {wb_valid_o, issue_ready_o, busy_o}, wb_data_o, wb_rd_o, ref_mdu(ops[i], as[i], bs[i]), i); end
      step();
    end
    wb_ready_i = 1'b0;
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL b2b_end_idle: got %b want 0", busy_o); end
  endtask

  task automatic test_reset_mid_exec();
    next_stall = 10;
    issue_valid_i = 1'b1; issue_op_i = OP_DIVU; issue_a_i = 32'd77; issue_b_i = 32'd5; issue_rd_i = 5'd12;
    step();
    issue_valid_i = 1'b0;
    step();
    arstn_i = 1'b0;
    #1;
    n_cmp++; if ({mdu_req_o, mdu_kill_o} !== 2'b10) begin n_bad++; $display("FAIL rst_exec_nokill: got req/kill=%b want 10", {mdu_req_o, mdu_kill_o}); end
    step();
    arstn_i = 1'b1;
    #1;
    n_cmp++; if ({busy_o, mdu_req_o, wb_valid_o, issue_ready_o, mdu_op_o, wb_rd_o, mdu_port_a_o} !== {4'b0001, 3'd0, 5'd0, 32'd0}) begin
      n_bad++; $display("FAIL rst_exec_idle: got b/r/v/rdy=%b op=%0d rd=%0d a=%h want 0001 0 0 0",
                        {busy_o, mdu_req_o, wb_valid_o, issue_ready_o}, mdu_op_o, wb_rd_o, mdu_port_a_o); end
    step();
  endtask

`ifdef RV_MDU_CTRL_WDT_EN
  task automatic test_wdt();
    int c;
    next_stall = 1000;
    issue_valid_i = 1'b1; issue_op_i = OP_DIV; issue_a_i = 32'd50; issue_b_i = 32'd7; issue_rd_i = 5'd17;
    step();
    issue_valid_i = 1'b0;
    #1;
    c = 1;
    while (mdu_kill_o !== 1'b1 && c < 100) begin step(); #1; c++; end
    n_cmp++; if (c != WDT) begin n_bad++; $display("FAIL wdt_cycles: got %0d want %0d", c, WDT); end
    step();
    n_cmp++; if ({wb_valid_o, err_o, mdu_kill_o, wb_data_o, wb_rd_o} !== {3'b110, 32'd0, 5'd17}) begin
      n_bad++; $display("FAIL wdt_result: got v/e/k=%b data=%h rd=%0d want 110 0 17", {wb_valid_o, err_o, mdu_kill_o}, wb_data_o, wb_rd_o); end
    wb_ready_i = 1'b1;
    step();
    wb_ready_i = 1'b0;
    run_op(OP_MUL, 32'd5, 32'd9, 5'd2, 0, 0);
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_flush_exec();
    test_flush_done_idle();
    test_back_to_back();
    test_random();
    test_reset_mid_exec();
`ifdef RV_MDU_CTRL_WDT_EN
    test_wdt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
